bram_port_arbiter: RTL and testbench

Shares the single data-side BRAM port between the CPU load/store path and the UART debug memory-access unit. It arbitrates word requests and registers the winning request onto the BRAM port. Read data is routed back to the owning requester with a fixed two-cycle latency. A debug lock lets the host take exclusive ownership of the port for bulk program load and readback.

---
 rtl/bram_arb_pkg.sv | 32 +++
 rtl/bram_arb_pipe.sv | 63 ++++++
 rtl/bram_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// -----------------------------------------------------------------------------
// bram_arb_pkg
// Shared definitions for the data-side BRAM port arbiter:
//   - default address/data widths of the BRAM port
//   - owner encoding carried in the read-return tag
//   - arbitration state encoding
//   - the per-stage pipeline tag structure
// -----------------------------------------------------------------------------
package bram_arb_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        LOCK_PEND = 2'd1,
        LOCKED    = 2'd2
    } arb_state_e;

    // One entry of the read-return pipeline.
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_read;
    } pipe_tag_t;

endpackage : bram_arb_pkg

// File: rtl/bram_arb_pipe.sv
// -----------------------------------------------------------------------------
// bram_arb_pipe
// Two-stage tag pipeline that follows every accepted BRAM access so the read
// data returned by the BRAM can be steered to the requester that issued it.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset; discards all in-flight tags
//   acc_valid    an access was accepted this cycle
//   acc_owner    owner of the accepted access
//   acc_is_read  accepted access is a read (byte enables all zero)
//   cpu_rvalid   CPU read data valid (2 cycles after acceptance)
//   dbg_rvalid   debug read data valid (2 cycles after acceptance)
//   cpu_inflight stage 1 holds a CPU tag
// -----------------------------------------------------------------------------
module bram_arb_pipe
    import bram_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   acc_valid,
    input  owner_e acc_owner,
    input  logic   acc_is_read,
    output logic   cpu_rvalid,
    output logic   dbg_rvalid,
    output logic   cpu_inflight
);

    // Stage 1 is aligned with the registered BRAM command; stage 2 is aligned
    // with the BRAM read data.
    pipe_tag_t stage1_reg;
    pipe_tag_t stage2_reg;
    pipe_tag_t stage1_next;

    always_comb begin
        stage1_next         = '0;
        stage1_next.valid   = acc_valid;
        stage1_next.owner   = acc_owner;
        stage1_next.is_read = acc_is_read;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage1_reg <= '0;
            stage2_reg <= '0;
        end else begin
            stage1_reg <= stage1_next;
            stage2_reg <= stage1_reg;
        end
    end

    assign cpu_rvalid = stage2_reg.valid && stage2_reg.is_read &&
                        (stage2_reg.owner == OWNER_CPU);
    assign dbg_rvalid = stage2_reg.valid && stage2_reg.is_read &&
                        (stage2_reg.owner == OWNER_DBG);

    // The stage-2 tag retires in the current cycle, so after the next edge a
    // CPU tag can only remain if stage 1 holds one now (the CPU cannot be
    // granted while the lock is pending). This lets the lock handover finish
    // within two cycles of entering LOCK_PEND.
    assign cpu_inflight = stage1_reg.valid && (stage1_reg.owner == OWNER_CPU);

endmodule : bram_arb_pipe

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
// Shares the single data-side BRAM port between the CPU load/store path and
// the UART debug memory-access unit. The winning request is registered onto
// the BRAM port; read data returns to its owner two cycles after acceptance.
// A debug lock gives the host exclusive ownership of the port.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   cpu_req/addr/we/wdata        CPU request (we==0 is a read)
//   cpu_gnt                      CPU request accepted this cycle (combinational)
//   cpu_rvalid/cpu_rdata         CPU read return
//   dbg_req/lock/addr/we/wdata   debug request and exclusive-ownership request
//   dbg_gnt                      debug request accepted this cycle (combinational)
//   dbg_rvalid/dbg_rdata         debug read return
//   dbg_locked                   exclusive ownership in effect
//   bram_en/addr/we/din/dout     BRAM port (dout valid one cycle after en)
//
// Optional feature macro: BRAM_ARB_STATS_EN
//   adds cpu_acc_cnt, dbg_acc_cnt, cpu_stall_cnt (32-bit, wrapping).
// -----------------------------------------------------------------------------
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int MAX_WAIT   = 8,
    localparam int WE_WIDTH   = DATA_WIDTH / 8,
    localparam int CNT_W      = $clog2(MAX_WAIT + 1)
)
(
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WE_WIDTH-1:0]   cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  dbg_req,
    input  logic                  dbg_lock,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [WE_WIDTH-1:0]   dbg_we,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_locked,

    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [WE_WIDTH-1:0]   bram_we,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [31:0]           cpu_acc_cnt,
    output logic [31:0]           dbg_acc_cnt,
    output logic [31:0]           cpu_stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(MAX_WAIT);

    arb_state_e             state_reg;
    arb_state_e             state_next;
    logic [CNT_W-1:0]       wait_cnt_reg;
    logic [CNT_W-1:0]       wait_cnt_next;

    logic                   cpu_gnt_next;
    logic                   dbg_gnt_next;
    logic                   cpu_acc;
    logic                   dbg_acc;
    logic                   any_acc;

    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [WE_WIDTH-1:0]    win_we;
    logic [DATA_WIDTH-1:0]  win_wdata;
    owner_e                 win_owner;

    logic                   bram_en_reg;
    logic [ADDR_WIDTH-1:0]  bram_addr_reg;
    logic [WE_WIDTH-1:0]    bram_we_reg;
    logic [DATA_WIDTH-1:0]  bram_din_reg;

    logic                   cpu_inflight;

    // -------------------------------------------------------------------------
    // Arbitration FSM: grants and next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cpu_gnt_next = 1'b0;
        dbg_gnt_next = 1'b0;

        case (state_reg)
            ARB: begin
                if (cpu_req && dbg_req) begin
                    // CPU has priority until debug has lost MAX_WAIT times.
                    if (wait_cnt_reg == WAIT_MAX_C) begin
                        dbg_gnt_next = 1'b1;
                    end else begin
                        cpu_gnt_next = 1'b1;
                    end
                end else begin
                    cpu_gnt_next = cpu_req;
                    dbg_gnt_next = dbg_req;
                end
                if (dbg_lock) begin
                    state_next = LOCK_PEND;
                end
            end

            LOCK_PEND: begin
                dbg_gnt_next = dbg_req;
                if (!dbg_lock) begin
                    state_next = ARB;
                end else if (!cpu_inflight) begin
                    state_next = LOCKED;
                end
            end

            LOCKED: begin
                dbg_gnt_next = dbg_req;
                if (!dbg_lock) begin
                    state_next = ARB;
                end
            end

            default: begin
                state_next = ARB;
            end
        endcase

        // Grants are combinational, so hold them low while in reset.
        if (!rst_n) begin
            cpu_gnt_next = 1'b0;
            dbg_gnt_next = 1'b0;
        end
    end

    assign cpu_gnt = cpu_gnt_next;
    assign dbg_gnt = dbg_gnt_next;
    assign cpu_acc = cpu_req && cpu_gnt_next;
    assign dbg_acc = dbg_req && dbg_gnt_next;
    assign any_acc = cpu_acc || dbg_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ARB;
        end else begin
            state_reg <= state_next;
        end
    end

    assign dbg_locked = (state_reg == LOCKED);

    // -------------------------------------------------------------------------
    // Debug starvation counter
    // -------------------------------------------------------------------------
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (dbg_acc) begin
            wait_cnt_next = '0;
        end else if (dbg_req && !dbg_gnt_next && (wait_cnt_reg != WAIT_MAX_C)) begin
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: register the winning request onto the BRAM port
    // -------------------------------------------------------------------------
    always_comb begin
        win_addr  = cpu_addr;
        win_we    = cpu_we;
        win_wdata = cpu_wdata;
        win_owner = OWNER_CPU;
        if (dbg_acc) begin
            win_addr  = dbg_addr;
            win_we    = dbg_we;
            win_wdata = dbg_wdata;
            win_owner = OWNER_DBG;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bram_en_reg   <= 1'b0;
            bram_addr_reg <= '0;
            bram_we_reg   <= '0;
            bram_din_reg  <= '0;
        end else if (any_acc) begin
            bram_en_reg   <= 1'b1;
            bram_addr_reg <= win_addr;
            bram_we_reg   <= win_we;
            bram_din_reg  <= win_wdata;
        end else begin
            // Idle: disable the port and never write; addr/din hold.
            bram_en_reg   <= 1'b0;
            bram_we_reg   <= '0;
        end
    end

    assign bram_en   = bram_en_reg;
    assign bram_addr = bram_addr_reg;
    assign bram_we   = bram_we_reg;
    assign bram_din  = bram_din_reg;

    // -------------------------------------------------------------------------
    // Read-return tag pipeline
    // -------------------------------------------------------------------------
    bram_arb_pipe u_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .acc_valid    (any_acc),
        .acc_owner    (win_owner),
        .acc_is_read  (win_we == '0),
        .cpu_rvalid   (cpu_rvalid),
        .dbg_rvalid   (dbg_rvalid),
        .cpu_inflight (cpu_inflight)
    );

    // Read data is shared; rvalid tells each requester when it is theirs.
    // Forced to zero while reset is asserted so every output reads 0.
    assign cpu_rdata = rst_n ? bram_dout : '0;
    assign dbg_rdata = rst_n ? bram_dout : '0;

`ifdef BRAM_ARB_STATS_EN
    // -------------------------------------------------------------------------
    // Access statistics (wrap modulo 2^32)
    // -------------------------------------------------------------------------
    logic [31:0] cpu_acc_cnt_reg;
    logic [31:0] dbg_acc_cnt_reg;
    logic [31:0] cpu_stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_acc_cnt_reg   <= '0;
            dbg_acc_cnt_reg   <= '0;
            cpu_stall_cnt_reg <= '0;
        end else begin
            if (cpu_acc) begin
                cpu_acc_cnt_reg <= cpu_acc_cnt_reg + 32'd1;
            end
            if (dbg_acc) begin
                dbg_acc_cnt_reg <= dbg_acc_cnt_reg + 32'd1;
            end
            if (cpu_req && !cpu_gnt_next) begin
                cpu_stall_cnt_reg <= cpu_stall_cnt_reg + 32'd1;
            end
        end
    end

    assign cpu_acc_cnt   = cpu_acc_cnt_reg;
    assign dbg_acc_cnt   = dbg_acc_cnt_reg;
    assign cpu_stall_cnt = cpu_stall_cnt_reg;
`endif

endmodule : bram_port_arbiter

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
// Self-checking bench for bram_port_arbiter. A behavioural BRAM drives
// bram_dout; a monitor keeps a shadow memory and a queue of expected read
// returns, checking the registered BRAM command and the rvalid/rdata stream
// every cycle. Scenario tasks check grants and lock behaviour inline.
// Build with +define+BRAM_ARB_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [WW-1:0] cpu_we;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req;
    logic          dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic [WW-1:0] dbg_we;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_locked;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [WW-1:0] bram_we;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
`ifdef BRAM_ARB_STATS_EN
    logic [31:0]   cpu_acc_cnt;
    logic [31:0]   dbg_acc_cnt;
    logic [31:0]   cpu_stall_cnt;
`endif

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_WAIT   (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_lock   (dbg_lock),
        .dbg_addr   (dbg_addr),
        .dbg_we     (dbg_we),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .dbg_locked (dbg_locked),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .bram_we    (bram_we),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout)
`ifdef BRAM_ARB_STATS_EN
        ,
        .cpu_acc_cnt   (cpu_acc_cnt),
        .dbg_acc_cnt   (dbg_acc_cnt),
        .cpu_stall_cnt (cpu_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        bit          owner;   // 0 = CPU, 1 = debug
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] iv;
        iv = 32'(i);
        return 32'hA500_0000 ^ (iv * 32'h0101_0101);
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Behavioural BRAM: read-first, one cycle read latency.
    task automatic run_bram_model;
        logic [7:0] idx;
        forever begin
            @(posedge clk);
            if (bram_en) begin
                idx = bram_addr[9:2];
                bram_dout <= mem[idx];
                for (int b = 0; b < WW; b++) begin
                    if (bram_we[b]) mem[idx][b*8 +: 8] = bram_din[b*8 +: 8];
                end
            end
        end
    endtask

    // Per-cycle monitor: BRAM command stage and read-return scoreboard.
    task automatic run_monitor;
        logic          prev_acc = 1'b0;
        logic [AW-1:0] p_addr   = '0;
        logic [WW-1:0] p_we     = '0;
        logic [DW-1:0] p_din    = '0;
        bit            p_owner  = 1'b0;
        logic          exp_cpu;
        logic          exp_dbg;
        logic [DW-1:0] edata;
        exp_t          e;
        logic [7:0]    idx;
        forever begin
            @(negedge clk);
            cyc++;
            checks++;
            if (prev_acc) begin
                if (bram_en !== 1'b1 || bram_addr !== p_addr || bram_we !== p_we || bram_din !== p_din) begin
                    errors++;
                    $display("FAIL bram_stage cyc=%0d: got en=%b addr=%h we=%b din=%h, expected en=1 addr=%h we=%b din=%h",
                             cyc, bram_en, bram_addr, bram_we, bram_din, p_addr, p_we, p_din);
                end
            end else if (bram_en !== 1'b0 || bram_we !== '0) begin
                errors++;
                $display("FAIL bram_idle cyc=%0d: got en=%b we=%b, expected en=0 we=0", cyc, bram_en, bram_we);
            end

            exp_cpu = 1'b0;
            exp_dbg = 1'b0;
            edata   = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                if (e.owner) exp_dbg = 1'b1;
                else         exp_cpu = 1'b1;
                edata = e.data;
            end
            checks++;
            if (cpu_rvalid !== exp_cpu || dbg_rvalid !== exp_dbg ||
                (exp_cpu && cpu_rdata !== edata) || (exp_dbg && dbg_rdata !== edata)) begin
                errors++;
                $display("FAIL rvalid cyc=%0d: got cpu_rvalid=%b dbg_rvalid=%b cpu_rdata=%h dbg_rdata=%h, expected cpu_rvalid=%b dbg_rvalid=%b data=%h",
                         cyc, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, exp_cpu, exp_dbg, edata);
            end

            if (!rst_n) begin
                exp_q.delete();
                prev_acc = 1'b0;
            end else begin
                checks++;
                if (cpu_gnt && dbg_gnt) begin
                    errors++;
                    $display("FAIL both_gnt cyc=%0d: got cpu_gnt=1 dbg_gnt=1, expected at most one", cyc);
                end
                prev_acc = 1'b0;
                if (cpu_req && cpu_gnt) begin
                    prev_acc = 1'b1; p_addr = cpu_addr; p_we = cpu_we; p_din = cpu_wdata; p_owner = 1'b0;
                end else if (dbg_req && dbg_gnt) begin
                    prev_acc = 1'b1; p_addr = dbg_addr; p_we = dbg_we; p_din = dbg_wdata; p_owner = 1'b1;
                end
                if (prev_acc) begin
                    idx = p_addr[9:2];
                    if (p_we == '0) begin
                        e.due = cyc + 2; e.owner = p_owner; e.data = shadow[idx];
                        exp_q.push_back(e);
                    end else begin
                        for (int b = 0; b < WW; b++) begin
                            if (p_we[b]) shadow[idx][b*8 +: 8] = p_din[b*8 +: 8];
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        checks++;
        if ((|{cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
               bram_en, bram_addr, bram_we, bram_din}) !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b addr=%h we=%b din=%h locked=%b rdata=%h, expected all 0",
                     bram_en, bram_addr, bram_we, bram_din, dbg_locked, cpu_rdata);
        end
        next_cycle();
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got cpu_gnt=%b dbg_gnt=%b, expected 0 0", cpu_gnt, dbg_gnt);
        end
        next_cycle();
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_cpu_read;
        next_cycle();
        cpu_req  = 1'b1;
        cpu_addr = 16'h0010;
        cpu_we   = '0;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_gnt: got cpu_gnt=%b dbg_gnt=%b, expected 1 0", cpu_gnt, dbg_gnt);
        end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bram_en !== 1'b1 || bram_addr !== 16'h0010 || bram_we !== 4'b0000) begin
            errors++;
            $display("FAIL cpu_read_bram: got en=%b addr=%h we=%b, expected 1 0010 0000", bram_en, bram_addr, bram_we);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || dbg_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_data: got rvalid=%b rdata=%h dbg_rvalid=%b, expected 1 deadbeef 0",
                     cpu_rvalid, cpu_rdata, dbg_rvalid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_pulse: got rvalid=%b one cycle later, expected 0", cpu_rvalid);
        end
    endtask

    task automatic test_contention;
        logic [1:0] exp_g;
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n    = 1'b1;
        cpu_req  = 1'b1;
        dbg_req  = 1'b1;
        cpu_addr = 16'h0040;
        dbg_addr = 16'h0080;
        cpu_we   = '0;
        dbg_we   = '0;
        for (int k = 1; k <= 18; k++) begin
            exp_g = (k % 9 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++;
            if ({cpu_gnt, dbg_gnt} !== exp_g) begin
                errors++;
                $display("FAIL contention_gnt k=%0d: got cpu_gnt,dbg_gnt=%b, expected %b", k, {cpu_gnt, dbg_gnt}, exp_g);
            end
            next_cycle();
            if (exp_g == 2'b10) cpu_addr = cpu_addr + 16'd4;
            else                dbg_addr = dbg_addr + 16'd4;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
`ifdef BRAM_ARB_STATS_EN
        @(negedge clk);
        checks++;
        if (cpu_acc_cnt !== 32'd16 || dbg_acc_cnt !== 32'd2 || cpu_stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL stats: got cpu_acc=%0d dbg_acc=%0d cpu_stall=%0d, expected 16 2 2",
                     cpu_acc_cnt, dbg_acc_cnt, cpu_stall_cnt);
        end
`endif
        repeat (3) next_cycle();
    endtask

    task automatic test_lock_drain;
        cpu_req = 1'b1;
        cpu_we  = '0;
        for (int k = 0; k < 4; k++) begin
            cpu_addr = 16'h0200 + 16'(4 * k);
            if (k == 3) dbg_lock = 1'b1;
            @(negedge clk);
            checks++;
            if (cpu_gnt !== 1'b1) begin
                errors++;
                $display("FAIL drain_b2b k=%0d: got cpu_gnt=%b, expected 1", k, cpu_gnt);
            end
            next_cycle();
        end
        cpu_addr = 16'h0300;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (cpu_gnt !== 1'b0) begin
                errors++;
                $display("FAIL drain_cpu_blocked k=%0d: got cpu_gnt=%b, expected 0", k, cpu_gnt);
            end
            if (k == 3) begin
                checks++;
                if (dbg_locked !== 1'b1 || exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL drain_locked: got dbg_locked=%b pending_reads=%0d, expected 1 0",
                             dbg_locked, exp_q.size());
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_locked_write;
        logic [31:0] exp_word;
        exp_word = init_word(16'h0100 >> 2);
        exp_word[15:0] = 16'h5678;
        dbg_req   = 1'b1;
        dbg_we    = 4'b0011;
        dbg_addr  = 16'h0100;
        dbg_wdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL locked_wr_gnt: got dbg_gnt=%b cpu_gnt=%b, expected 1 0", dbg_gnt, cpu_gnt);
        end
        next_cycle();
        dbg_req = 1'b0;
        dbg_we  = '0;
        @(negedge clk);
        checks++;
        if (bram_en !== 1'b1 || bram_we !== 4'b0011 || bram_addr !== 16'h0100 ||
            bram_din !== 32'h12345678 || cpu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL locked_wr_bram: got en=%b we=%b addr=%h din=%h cpu_gnt=%b, expected 1 0011 0100 12345678 0",
                     bram_en, bram_we, bram_addr, bram_din, cpu_gnt);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0 || cpu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL locked_wr_norvalid: got cpu_rvalid=%b dbg_rvalid=%b cpu_gnt=%b, expected 0 0 0",
                     cpu_rvalid, dbg_rvalid, cpu_gnt);
        end
        next_cycle();
        dbg_req = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL locked_rd_gnt: got dbg_gnt=%b cpu_gnt=%b, expected 1 0", dbg_gnt, cpu_gnt);
        end
        next_cycle();
        dbg_req = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== exp_word || cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL locked_readback: got dbg_rvalid=%b data=%h cpu_rvalid=%b, expected 1 %h 0",
                     dbg_rvalid, dbg_rdata, cpu_rvalid, exp_word);
        end
        next_cycle();
        dbg_lock = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_locked !== 1'b1 || cpu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL unlock_same_cycle: got dbg_locked=%b cpu_gnt=%b, expected 1 0", dbg_locked, cpu_gnt);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (dbg_locked !== 1'b0 || cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL unlock_next: got dbg_locked=%b cpu_gnt=%b, expected 0 1", dbg_locked, cpu_gnt);
        end
        next_cycle();
        cpu_req = 1'b0;
        repeat (3) next_cycle();
    endtask

    task automatic test_reset_mid_read;
        dbg_req  = 1'b1;
        dbg_addr = 16'h0020;
        dbg_we   = '0;
        @(negedge clk);
        checks++;
        if (dbg_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_rd_gnt: got dbg_gnt=%b, expected 1", dbg_gnt);
        end
        next_cycle();
        dbg_req = 1'b0;
        rst_n   = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if ((|{cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
               bram_en, bram_addr, bram_we, bram_din}) !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got dbg_rvalid=%b en=%b addr=%h din=%h rdata=%h, expected all 0",
                     dbg_rvalid, bram_en, bram_addr, bram_din, dbg_rdata);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_rvalid !== 1'b0 || bram_en !== 1'b0 || dbg_locked !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: got dbg_rvalid=%b en=%b locked=%b, expected 0 0 0",
                     dbg_rvalid, bram_en, dbg_locked);
        end
        next_cycle();
        cpu_req  = 1'b1;
        cpu_addr = 16'h0030;
        cpu_we   = '0;
        dbg_req  = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_state_arb: got cpu_gnt=%b dbg_gnt=%b, expected 1 0", cpu_gnt, dbg_gnt);
        end
        next_cycle();
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (3) next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
        mem[4]    = 32'hDEADBEEF;
        shadow[4] = 32'hDEADBEEF;
        bram_dout = '0;
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        cpu_we    = '0;
        cpu_wdata = '0;
        dbg_req   = 1'b0;
        dbg_lock  = 1'b0;
        dbg_addr  = '0;
        dbg_we    = '0;
        dbg_wdata = '0;

        fork
            run_bram_model();
            run_monitor();
        join_none

        test_reset();
        test_cpu_read();
        test_contention();
        test_lock_drain();
        test_locked_write();
        test_reset_mid_read();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bram_port_arbiter
